// File: rtl/tiny_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tiny_alu_pkg / tiny_alu_cmd_sequencer
//  Brief    : Command front-end for tiny_alu. Buffers requests in a FIFO,
//             issues them one at a time as start pulses, waits for done with
//             a timeout guard and returns tagged, in-order responses.
//  Revision : 1.0  initial release
// ============================================================================

package tiny_alu_pkg;
    localparam int OPCODE_BITS = 3;
endpackage

module tiny_alu_cmd_sequencer
    import tiny_alu_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic [OPCODE_BITS-1:0]       cmd_opcode_i,
    input  logic [DATA_W-1:0]            cmd_a_i,
    input  logic [DATA_W-1:0]            cmd_b_i,
    input  logic [TAG_W-1:0]             cmd_tag_i,
    output logic                         alu_start_o,
    output logic [OPCODE_BITS-1:0]       alu_opcode_o,
    output logic [DATA_W-1:0]            alu_a_o,
    output logic [DATA_W-1:0]            alu_b_o,
    input  logic [2*DATA_W-1:0]          alu_result_i,
    input  logic                         alu_done_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [2*DATA_W-1:0]          rsp_result_o,
    output logic [TAG_W-1:0]             rsp_tag_o,
    output logic                         rsp_err_o,
    output logic                         busy_o,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o
);

    localparam int c_ptr_w   = $clog2(FIFO_DEPTH);
    localparam int c_lvl_w   = c_ptr_w + 1;
    localparam int c_entry_w = OPCODE_BITS + 2*DATA_W + TAG_W;
    localparam int c_cnt_w   = $clog2(TIMEOUT + 1);

    localparam logic [c_lvl_w-1:0] c_full_lvl    = c_lvl_w'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_timeout_cnt = c_cnt_w'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [c_entry_w-1:0]   r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [c_lvl_w-1:0]     r_level;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic [c_entry_w-1:0]   w_push_entry;
    logic [c_entry_w-1:0]   w_head;

    logic [OPCODE_BITS-1:0] w_head_op;
    logic [DATA_W-1:0]      w_head_a;
    logic [DATA_W-1:0]      w_head_b;
    logic [TAG_W-1:0]       w_head_tag;

    assign w_full       = (r_level == c_full_lvl);
    assign w_empty      = (r_level == '0);
    // Ready is a pure function of occupancy; a same-cycle pop does not open it.
    assign w_push       = cmd_valid_i & ~w_full;
    assign w_push_entry = {cmd_opcode_i, cmd_a_i, cmd_b_i, cmd_tag_i};
    assign w_head       = r_mem[r_rd_ptr];
    assign {w_head_op, w_head_a, w_head_b, w_head_tag} = w_head;

    // Storage array: written on push, no reset needed since level gates reads.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap freely.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_lvl_w'(1);
                2'b01:   r_level <= r_level - c_lvl_w'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_capture;
    logic                   w_timeout;

    logic [c_cnt_w-1:0]     r_cnt;
    logic [OPCODE_BITS-1:0] r_alu_opcode;
    logic [DATA_W-1:0]      r_alu_a;
    logic [DATA_W-1:0]      r_alu_b;
    logic [TAG_W-1:0]       r_tag;
    logic [2*DATA_W-1:0]    r_rsp_result;
    logic [TAG_W-1:0]       r_rsp_tag;
    logic                   r_rsp_err;

    // State register.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-state strobes; done is only honoured in WAIT and beats timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (alu_done_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (r_cnt == c_timeout_cnt) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Issue registers, timeout counter and response payload registers.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_cnt        <= '0;
            r_alu_opcode <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_tag        <= '0;
            r_rsp_result <= '0;
            r_rsp_tag    <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            if (w_pop) begin
                r_alu_opcode <= w_head_op;
                r_alu_a      <= w_head_a;
                r_alu_b      <= w_head_b;
                r_tag        <= w_head_tag;
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
            if (w_capture) begin
                r_rsp_result <= alu_result_i;
                r_rsp_tag    <= r_tag;
                r_rsp_err    <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_result <= '0;
                r_rsp_tag    <= r_tag;
                r_rsp_err    <= 1'b1;
            end
        end
    end

    assign cmd_ready_o  = ~w_full;
    assign alu_start_o  = (r_state == S_ISSUE);
    assign alu_opcode_o = r_alu_opcode;
    assign alu_a_o      = r_alu_a;
    assign alu_b_o      = r_alu_b;
    assign rsp_valid_o  = (r_state == S_RESP);
    assign rsp_result_o = r_rsp_result;
    assign rsp_tag_o    = r_rsp_tag;
    assign rsp_err_o    = r_rsp_err;
    assign busy_o       = (r_state != S_IDLE);
    assign fifo_level_o = r_level;

endmodule

`default_nettype wire

// File: tb/tb_tiny_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tiny_alu_cmd_sequencer
//  Brief    : Self-checking bench for tiny_alu_cmd_sequencer with a one-cycle
//             ALU model and an in-order response scoreboard.
//  Revision : 1.0  initial release
// ============================================================================

module tb_tiny_alu_cmd_sequencer;
    import tiny_alu_pkg::*;

    localparam int DATA_W     = 8;
    localparam int TAG_W      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 15;

    localparam logic [2:0] c_op_nop = 3'd0;
    localparam logic [2:0] c_op_add = 3'd1;
    localparam logic [2:0] c_op_and = 3'd2;
    localparam logic [2:0] c_op_xor = 3'd3;
    localparam logic [2:0] c_op_mul = 3'd4;
    localparam logic [2:0] c_op_bad = 3'd7;

    logic                         clk = 1'b0;
    logic                         reset_n_i;
    logic                         cmd_valid_i;
    logic                         cmd_ready_o;
    logic [OPCODE_BITS-1:0]       cmd_opcode_i;
    logic [DATA_W-1:0]            cmd_a_i;
    logic [DATA_W-1:0]            cmd_b_i;
    logic [TAG_W-1:0]             cmd_tag_i;
    logic                         alu_start_o;
    logic [OPCODE_BITS-1:0]       alu_opcode_o;
    logic [DATA_W-1:0]            alu_a_o;
    logic [DATA_W-1:0]            alu_b_o;
    logic [2*DATA_W-1:0]          alu_result_i;
    logic                         alu_done_i;
    logic                         rsp_valid_o;
    logic                         rsp_ready_i;
    logic [2*DATA_W-1:0]          rsp_result_o;
    logic [TAG_W-1:0]             rsp_tag_o;
    logic                         rsp_err_o;
    logic                         busy_o;
    logic [$clog2(FIFO_DEPTH):0]  fifo_level_o;

    tiny_alu_cmd_sequencer #(
        .DATA_W     (DATA_W),
        .TAG_W      (TAG_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) u_dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_opcode_i (cmd_opcode_i),
        .cmd_a_i      (cmd_a_i),
        .cmd_b_i      (cmd_b_i),
        .cmd_tag_i    (cmd_tag_i),
        .alu_start_o  (alu_start_o),
        .alu_opcode_o (alu_opcode_o),
        .alu_a_o      (alu_a_o),
        .alu_b_o      (alu_b_o),
        .alu_result_i (alu_result_i),
        .alu_done_i   (alu_done_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_result_o (rsp_result_o),
        .rsp_tag_o    (rsp_tag_o),
        .rsp_err_o    (rsp_err_o),
        .busy_o       (busy_o),
        .fifo_level_o (fifo_level_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  tag;
        logic [15:0] res;
        logic        err;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    vec_t cur;
    vec_t tbl[6];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_accept_cyc = 0;
    int   last_start_cyc = 0;
    int   last_rise_cyc = 0;
    int   rsp_count = 0;
    bit   accepted = 1'b0;
    bit   start_seen = 1'b0;
    bit   prev_rsp_valid = 1'b0;
    bit   model_en = 1'b1;
    bit   inject_req = 1'b0;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] alu_model(input logic [2:0] op, input logic [7:0] a,
                                              input logic [7:0] b);
        case (op)
            c_op_add: alu_model = {8'h00, a} + {8'h00, b};
            c_op_and: alu_model = {8'h00, a & b};
            c_op_xor: alu_model = {8'h00, a ^ b};
            c_op_mul: alu_model = {8'h00, a} * {8'h00, b};
            default:  alu_model = 16'h0000;
        endcase
    endfunction

    // One clock: observe at the falling edge, then drive ALU outputs just after the rising edge.
    task automatic tick();
        bit          fire;
        logic [15:0] res;
        exp_t        e;
        @(negedge clk);
        accepted = 1'b0;
        if (rsp_valid_o === 1'b1 && !prev_rsp_valid) last_rise_cyc = cyc;
        prev_rsp_valid = (rsp_valid_o === 1'b1);
        if (rsp_valid_o === 1'b1 && rsp_ready_i) begin
            rsp_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got tag=%0d result=0x%0h, required no response",
                         rsp_tag_o, rsp_result_o);
            end else begin
                e = exp_q.pop_front();
                check_val("rsp_result", rsp_result_o, e.res);
                check_val("rsp_tag", rsp_tag_o, e.tag);
                check_val("rsp_err", rsp_err_o, e.err);
            end
        end
        if (cmd_valid_i && cmd_ready_o === 1'b1) begin
            accepted = 1'b1;
            last_accept_cyc = cyc;
            e.res = cur.res;
            e.tag = cur.tag;
            e.err = cur.err;
            exp_q.push_back(e);
        end
        if (alu_start_o === 1'b1) begin
            last_start_cyc = cyc;
            start_seen = 1'b1;
        end
        fire = model_en && (alu_start_o === 1'b1) && (alu_opcode_o <= c_op_mul);
        res  = alu_model(alu_opcode_o, alu_a_o, alu_b_o);
        @(posedge clk);
        #1;
        alu_done_i   = fire | inject_req;
        alu_result_i = fire ? res : 16'hBEEF;
        inject_req   = 1'b0;
        cyc++;
    endtask

    task automatic drive_cmd(input vec_t v);
        cur          = v;
        cmd_opcode_i = v.op;
        cmd_a_i      = v.a;
        cmd_b_i      = v.b;
        cmd_tag_i    = v.tag;
        cmd_valid_i  = 1'b1;
    endtask

    task automatic send(input vec_t v, input int budget);
        bit ok;
        ok = 1'b0;
        drive_cmd(v);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (accepted) begin
                ok = 1'b1;
                break;
            end
        end
        cmd_valid_i = 1'b0;
        check_val("cmd_accepted", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        check_val("drain_remaining", exp_q.size(), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_ready"}, {31'd0, cmd_ready_o}, 32'd1);
        check_val({tag, "_level"}, fifo_level_o, 32'd0);
        check_val({tag, "_ctrl"}, {alu_start_o, rsp_valid_o, busy_o, rsp_err_o}, 32'd0);
        check_val({tag, "_issue"}, {alu_opcode_o, alu_a_o, alu_b_o}, 32'd0);
        check_val({tag, "_payload"}, {rsp_result_o, rsp_tag_o}, 32'd0);
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic [3:0] tag, input logic [15:0] res, input logic err);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.tag = tag; v.res = res; v.err = err;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int rc;

        tbl[0] = mk(c_op_mul, 8'hFF, 8'hFF, 4'd1, 16'hFE01, 1'b0);
        tbl[1] = mk(c_op_xor, 8'hA5, 8'h0F, 4'd2, 16'h00AA, 1'b0);
        tbl[2] = mk(c_op_nop, 8'h12, 8'h34, 4'd4, 16'h0000, 1'b0);
        tbl[3] = mk(c_op_and, 8'hF0, 8'h3C, 4'd5, 16'h0030, 1'b0);
        tbl[4] = mk(c_op_add, 8'h80, 8'h80, 4'd6, 16'h0100, 1'b0);
        tbl[5] = mk(c_op_mul, 8'h0C, 8'h0B, 4'd8, 16'h0084, 1'b0);

        reset_n_i    = 1'b0;
        cmd_valid_i  = 1'b0;
        cmd_opcode_i = '0;
        cmd_a_i      = '0;
        cmd_b_i      = '0;
        cmd_tag_i    = '0;
        alu_result_i = '0;
        alu_done_i   = 1'b0;
        rsp_ready_i  = 1'b1;
        cur          = mk(3'd0, 8'd0, 8'd0, 4'd0, 16'd0, 1'b0);
        tick();
        tick();
        reset_n_i = 1'b1;
        check_reset_state("reset");

        // Single ADD: start 2 cycles and response 4 cycles after acceptance.
        send(mk(c_op_add, 8'hFF, 8'h01, 4'd3, 16'h0100, 1'b0), 5);
        start_seen = 1'b0;
        wait_drain(20);
        check_val("lat_start", last_start_cyc - last_accept_cyc, 32'd2);
        check_val("lat_rsp", last_rise_cyc - last_accept_cyc, 32'd4);

        // Back-to-back table of operations through the FIFO.
        for (int i = 0; i < 6; i++) send(tbl[i], 20);
        wait_drain(60);

        // Backpressure: one held in RESP plus a full FIFO.
        rsp_ready_i = 1'b0;
        n = 0;
        drive_cmd(mk(c_op_add, 8'd0, 8'h10, 4'd0, 16'h0010, 1'b0));
        for (int k = 0; k < 12 && n < 8; k++) begin
            tick();
            if (accepted) begin
                n++;
                drive_cmd(mk(c_op_add, 8'(n), 8'h10, 4'(n), 16'h0010 + 16'(n), 1'b0));
            end
        end
        check_val("bp_accepted", n, 32'd5);
        check_val("bp_ready", {31'd0, cmd_ready_o}, 32'd0);
        check_val("bp_level", fifo_level_o, 32'd4);
        check_val("bp_busy_valid", {busy_o, rsp_valid_o}, 32'd3);
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        wait_drain(60);

        // Illegal opcode resolves by timeout; the next ADD is unaffected.
        send(mk(c_op_bad, 8'h01, 8'h02, 4'hA, 16'h0000, 1'b1), 5);
        wait_drain(40);
        check_val("timeout_lat", last_rise_cyc - last_start_cyc, 32'(TIMEOUT + 2));
        send(mk(c_op_add, 8'h02, 8'h03, 4'hB, 16'h0005, 1'b0), 5);
        wait_drain(20);

        // Reset while waiting on the ALU, followed by a stray done.
        model_en   = 1'b0;
        start_seen = 1'b0;
        send(mk(c_op_add, 8'h01, 8'h01, 4'hC, 16'h0002, 1'b0), 5);
        for (int i = 0; i < 10 && !start_seen; i++) tick();
        check_val("rst_start_seen", {31'd0, start_seen}, 32'd1);
        tick();
        reset_n_i = 1'b0;
        tick();
        reset_n_i = 1'b1;
        exp_q.delete();
        model_en = 1'b1;
        check_reset_state("wait_reset");
        rc = rsp_count;
        inject_req = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check_val("rst_no_rsp", rsp_count - rc, 32'd0);
        check_val("rst_idle", {busy_o, fifo_level_o}, 32'd0);
        check_val("rst_payload", {rsp_result_o, rsp_tag_o, rsp_err_o}, 32'd0);

        // Stray done while a response is being held.
        rsp_ready_i = 1'b0;
        send(mk(c_op_add, 8'h04, 8'h05, 4'hD, 16'h0009, 1'b0), 5);
        for (int i = 0; i < 20 && rsp_valid_o !== 1'b1; i++) tick();
        check_val("resp_valid_held", {31'd0, rsp_valid_o}, 32'd1);
        inject_req = 1'b1;
        tick();
        tick();
        tick();
        check_val("resp_hold_payload", {rsp_valid_o, rsp_err_o, rsp_tag_o, rsp_result_o},
                  {12'd0, 1'b1, 1'b0, 4'hD, 16'h0009});
        rsp_ready_i = 1'b1;
        rc = rsp_count;
        wait_drain(10);
        for (int i = 0; i < 6; i++) tick();
        check_val("resp_single", rsp_count - rc, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tiny_alu_cmd_sequencer.md
# tiny_alu_cmd_sequencer

Upstream command front-end for `tiny_alu`. It accepts operation requests on a valid/ready command channel and buffers them in a small FIFO. It issues them one at a time to the ALU as single-cycle `start` pulses, then waits for `done` with a timeout guard. Each outcome is returned in order on a valid/ready response channel carrying the caller's tag and an error flag.

## Interface
- `DATA_W`, default 8: ALU operand width; results are `2*DATA_W`.
- `TAG_W`, default 4: opaque request tag, returned unchanged.
- `FIFO_DEPTH`, default 4: command FIFO entries; power of two, ≥2.
- `TIMEOUT`, default 15: max WAIT cycles without `alu_done_i` before an error response; ≥2.
- `clk_i` in 1: single clock; all logic on rising edge.
- `reset_n_i` in 1: reset, synchronous, active-low.
- `cmd_valid_i` in 1: command present.
- `cmd_ready_o` out 1: FIFO can accept a command.
- `cmd_opcode_i` in `OPCODE_BITS`: `tiny_alu_pkg` opcode.
- `cmd_a_i`, `cmd_b_i` in `DATA_W`: operands.
- `cmd_tag_i` in `TAG_W`: request tag.
- `alu_start_o` out 1: one-cycle issue pulse to the ALU.
- `alu_opcode_o` out `OPCODE_BITS`; `alu_a_o`, `alu_b_o` out `DATA_W`: operands to the ALU.
- `alu_result_i` in `2*DATA_W`; `alu_done_i` in 1: ALU outputs.
- `rsp_valid_o` out 1; `rsp_ready_i` in 1: response handshake.
- `rsp_result_o` out `2*DATA_W`; `rsp_tag_o` out `TAG_W`; `rsp_err_o` out 1: response payload.
- `busy_o` out 1: FSM not IDLE.
- `fifo_level_o` out `$clog2(FIFO_DEPTH)+1`: FIFO occupancy.

## Operation
- Opcodes from `tiny_alu_pkg`: NOP=0, ADD=1, AND=2, XOR=3, MUL=4. Any other value is illegal and is not rejected on entry. It is forwarded to the ALU and resolves via timeout.
- FIFO
  - Push when `cmd_valid_i & cmd_ready_o`.
  - `cmd_ready_o = ~full`. The ready does not look ahead to a same-cycle pop. Push and pop in the same cycle are legal and leave the level unchanged.
  - Entries are `{opcode,a,b,tag}`.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: when the FIFO is non-empty, pop the head into the issue registers (`alu_opcode_o`, `alu_a_o`, `alu_b_o`, tag) and go to ISSUE.
- ISSUE: `alu_start_o=1` for exactly this cycle. Clear the timeout counter. Go to WAIT.
- WAIT: `alu_start_o=0`. Increment the counter every cycle.
  - If `alu_done_i=1`, capture `alu_result_i`, set err=0, go to RESP.
  - Else, if the counter reaches `TIMEOUT`, set result=0 and err=1, go to RESP.
  - If done arrives in the same cycle the counter reaches `TIMEOUT`, done wins.
- RESP: `rsp_valid_o=1` with the payload held stable until `rsp_ready_i`. On the handshake, go to IDLE.
- `alu_done_i` is ignored outside WAIT; stray or late pulses are never captured.
- Responses are in strict command order. Only one operation is outstanding at the ALU.
- `alu_opcode_o`, `alu_a_o`, `alu_b_o` hold the last issued values between operations.

## Timing
- Reset (`reset_n_i=0` at a rising edge): next cycle all outputs are 0 except `cmd_ready_o=1`.
  - FIFO emptied, FSM in IDLE, counter 0.
  - An in-flight operation is dropped and produces no response, whether reset lands in ISSUE, WAIT or RESP.
- `cmd_ready_o` is low only when level==`FIFO_DEPTH`. Level updates the cycle after push or pop.
- Latency with an empty FIFO and an idle FSM, command accepted in cycle t:
  - IDLE pop at t+1.
  - `alu_start_o` at t+2.
  - `alu_done_i` expected at t+3.
  - `rsp_valid_o` at t+4 if `rsp_ready_i` is high.
- Throughput: one operation per 4 cycles at best.
- Timeout response: `rsp_valid_o` rises `TIMEOUT+2` cycles after `alu_start_o`.
- Backpressure: with `rsp_ready_i` low, RESP holds, the FIFO fills, and `cmd_ready_o` drops. Capacity is `FIFO_DEPTH` queued plus 1 held.
- `busy_o` is high in ISSUE, WAIT and RESP.

## Test plan
- ADD a=0xFF b=0x01 tag=3, ready always high → `alu_start_o` pulse 2 cycles after accept. `rsp_valid_o` 4 cycles after accept with result=0x0100, tag=3, err=0.
- MUL 0xFF×0xFF, then XOR 0xA5^0x0F, then NOP → results 0xFE01, 0x00AA, 0x0000 in order, all err=0.
- Hold `rsp_ready_i=0`, push tags 0..7 continuously → 5 accepted (tags 0..4), then `cmd_ready_o=0` and `fifo_level_o=4`. Release → tags 0..4 return in order with correct results.
- Opcode 7 with a=1, b=2 → no done; response err=1, result=0 exactly `TIMEOUT+2`=17 cycles after `alu_start_o`. A following ADD 2+3 completes normally with 0x0005.
- Reset asserted in WAIT, then the ALU model pulses done → all outputs 0 and `fifo_level_o=0` after reset. No response emitted; the stray done is ignored.
- Inject a spurious `alu_done_i` while in IDLE and in RESP → no extra response and payload unchanged.
